// File: rtl/interboard_tx_link.sv
// Inter-board serial transmitter: latches one {msg_type, number} frame, shifts it out MSB first,
// waits for the peer's ack with timeout/retry. Optional even-parity bit: define INTERBOARD_PARITY_EN.
module interboard_tx_link #(
    parameter int BIT_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 50000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       transmit,
    input  logic       ctrl_en,
    input  logic [2:0] ctrl_msg_type,
    input  logic [4:0] ctrl_number,
    input  logic       ack_in,
    output logic       inter_ready,
    output logic       tx_valid,
    output logic       tx_data,
    output logic       busy,
    output logic       link_err,
    output logic       overrun
);

`ifdef INTERBOARD_PARITY_EN
    localparam int FRAME_W = 9;
`else
    localparam int FRAME_W = 8;
`endif
    localparam int BT_W  = $clog2(BIT_CYCLES + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int RC_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int IDX_W = $clog2(FRAME_W);

    localparam logic [BT_W-1:0]  BIT_LAST  = BT_W'(BIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [RC_W-1:0]  RETRY_LIM = RC_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [FRAME_W-1:0]  r_frame;
    logic [BT_W-1:0]     r_bit_tmr;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [TO_W-1:0]     r_tmo_cnt;
    logic [RC_W-1:0]     r_retry_cnt;
    logic                r_ack_s1;
    logic                r_ack_s2;
    logic                r_ack_s3;
    logic                r_overrun;

    logic                w_sync_rst;
    logic                w_ack_rise;
    logic                w_accept;
    logic                w_bit_last;
    logic                w_frame_last;
    logic                w_tmo_last;
    logic [7:0]          w_msg;
    logic [FRAME_W-1:0]  w_frame_in;

    assign w_sync_rst   = rst | interboard_rst;
    assign w_ack_rise   = r_ack_s2 & ~r_ack_s3;
    assign w_accept     = (r_state == S_IDLE) & ctrl_en & transmit;
    assign w_bit_last   = (r_bit_tmr == BIT_LAST);
    assign w_frame_last = w_bit_last & (r_bit_idx == '0);
    assign w_tmo_last   = (r_tmo_cnt == TO_LAST);
    assign w_msg        = {ctrl_msg_type, ctrl_number};

`ifdef INTERBOARD_PARITY_EN
    assign w_frame_in = {w_msg, ^w_msg};
`else
    assign w_frame_in = w_msg;
`endif

    // Loss of transmit outranks everything in SEND/WAIT_ACK; an ack outranks a simultaneous timeout.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_next_state = r_state;
        inter_ready  = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 1'b0;
        busy         = 1'b0;
        link_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ctrl_en && transmit) w_next_state = S_SEND;
            end
            S_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = r_frame[r_bit_idx];
                if (!transmit)         w_next_state = S_IDLE;
                else if (w_frame_last) w_next_state = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                busy = 1'b1;
                if (!transmit)       w_next_state = S_IDLE;
                else if (w_ack_rise) w_next_state = S_DONE;
                else if (w_tmo_last) w_next_state = (r_retry_cnt < RETRY_LIM) ? S_SEND : S_ERR;
            end
            S_DONE: begin
                busy         = 1'b1;
                inter_ready  = 1'b1;
                w_next_state = S_IDLE;
            end
            S_ERR: begin
                link_err = 1'b1;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign overrun = r_overrun;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (w_sync_rst) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_bit_tmr   <= '0;
            r_bit_idx   <= '0;
            r_tmo_cnt   <= '0;
            r_retry_cnt <= '0;
            r_ack_s1    <= 1'b0;
            r_ack_s2    <= 1'b0;
            r_ack_s3    <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_ack_s1 <= ack_in;
            r_ack_s2 <= r_ack_s1;
            r_ack_s3 <= r_ack_s2;

            if (ctrl_en && busy) r_overrun <= 1'b1;
            if (w_accept)        r_frame   <= w_frame_in;

            // Every entry into SEND (first attempt or retry) restarts the shifter at the MSB.
            if (w_next_state == S_SEND && r_state != S_SEND) begin
                r_bit_tmr <= '0;
                r_bit_idx <= IDX_MSB;
            end else if (r_state == S_SEND) begin
                if (w_bit_last) begin
                    r_bit_tmr <= '0;
                    if (r_bit_idx != '0) r_bit_idx <= r_bit_idx - IDX_W'(1);
                end else begin
                    r_bit_tmr <= r_bit_tmr + BT_W'(1);
                end
            end

            if (r_state == S_WAIT_ACK && !w_tmo_last) r_tmo_cnt <= r_tmo_cnt + TO_W'(1);
            else                                      r_tmo_cnt <= '0;

            if (w_accept || w_next_state == S_IDLE)
                r_retry_cnt <= '0;
            else if (r_state == S_WAIT_ACK && w_next_state == S_SEND)
                r_retry_cnt <= r_retry_cnt + RC_W'(1);
        end
    end

endmodule

// File: tb/tb_interboard_tx_link.sv
// Self-checking bench for interboard_tx_link: directed scenarios with random payloads,
// expected serial streams derived from the message bits, optional parity when the macro is set.
module tb_interboard_tx_link;

    localparam int BC = 4;
    localparam int TO = 20;
    localparam int MR = 3;
`ifdef INTERBOARD_PARITY_EN
    localparam int FW = 9;
`else
    localparam int FW = 8;
`endif

    logic       clk            = 1'b0;
    logic       rst            = 1'b1;
    logic       interboard_rst = 1'b0;
    logic       transmit       = 1'b0;
    logic       ctrl_en        = 1'b0;
    logic [2:0] ctrl_msg_type  = '0;
    logic [4:0] ctrl_number    = '0;
    logic       ack_in         = 1'b0;
    logic       inter_ready;
    logic       tx_valid;
    logic       tx_data;
    logic       busy;
    logic       link_err;
    logic       overrun;

    int errors     = 0;
    int checks     = 0;
    int ready_seen = 0;
    int valid_seen = 0;

    interboard_tx_link #(
        .BIT_CYCLES (BC),
        .ACK_TIMEOUT(TO),
        .MAX_RETRY  (MR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .interboard_rst(interboard_rst),
        .transmit      (transmit),
        .ctrl_en       (ctrl_en),
        .ctrl_msg_type (ctrl_msg_type),
        .ctrl_number   (ctrl_number),
        .ack_in        (ack_in),
        .inter_ready   (inter_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .busy          (busy),
        .link_err      (link_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(inter_ready), 32'(0));
        check({tag, "_valid"}, 32'(tx_valid), 32'(0));
        check({tag, "_data"}, 32'(tx_data), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_err"}, 32'(link_err), 32'(0));
        check({tag, "_ovr"}, 32'(overrun), 32'(0));
    endtask

    task automatic send_req(input logic [2:0] t, input logic [4:0] n);
        ctrl_msg_type = t;
        ctrl_number   = n;
        ctrl_en       = 1'b1;
        tick();
        ctrl_en       = 1'b0;
    endtask

    // Expected stream: message bits MSB first, each held BC cycles, then optional even parity.
    task automatic run_frame(input logic [7:0] f, input int inject_at, input int abort_at);
        logic exp_q[$];
        int   ones;
        ones = 0;
        for (int k = 7; k >= 0; k--) begin
            exp_q.push_back(f[k]);
            ones += int'(f[k]);
        end
        if (FW == 9) exp_q.push_back((ones % 2) == 1);
        for (int c = 0; c < FW * BC; c++) begin
            check($sformatf("frame_cyc%0d", c), 32'({tx_valid, tx_data}), 32'({1'b1, exp_q[c / BC]}));
            if (c == inject_at) begin
                ctrl_en     = 1'b1;
                ctrl_number = 5'd9;
            end
            if (c == abort_at) transmit = 1'b0;
            tick();
            ctrl_en = 1'b0;
            if (c == abort_at) break;
        end
        if (abort_at < 0) check("frame_end", 32'(tx_valid), 32'(0));
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!tx_valid && k < budget) begin
            if (inter_ready) ready_seen++;
            tick();
            k++;
        end
        check("wait_valid", 32'(tx_valid), 32'(1));
    endtask

    task automatic observe(input int n);
        for (int k = 0; k < n; k++) begin
            if (inter_ready) ready_seen++;
            if (tx_valid) valid_seen++;
            tick();
        end
    endtask

    // Ack rise in cycle c must yield inter_ready exactly in cycle c+3.
    task automatic ack_and_check(input string tag);
        ack_in = 1'b1;
        tick();
        check({tag, "_ready_c1"}, 32'(inter_ready), 32'(0));
        tick();
        check({tag, "_ready_c2"}, 32'(inter_ready), 32'(0));
        ack_in = 1'b0;
        tick();
        check({tag, "_ready_c3"}, 32'(inter_ready), 32'(1));
        tick();
        check({tag, "_ready_c4"}, 32'(inter_ready), 32'(0));
        check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        logic [2:0] t;
        logic [4:0] n;
        int         k;

        tick();
        tick();
        check_all_zero("reset");
        rst      = 1'b0;
        transmit = 1'b1;
        tick();

        // Basic frame: F = 010_10001
        send_req(3'b010, 5'd17);
        run_frame(8'h51, -1, -1);
        check("basic_wait_busy", 32'(busy), 32'(1));
        ack_and_check("basic");

        // Ack edge while idle is ignored
        ready_seen = 0;
        ack_in = 1'b1;
        observe(3);
        ack_in = 1'b0;
        observe(3);
        check("idle_ack_ignored", 32'(ready_seen), 32'(0));

        // Random payloads
        for (int i = 0; i < 3; i++) begin
            t = 3'($urandom_range(7, 0));
            n = 5'($urandom_range(25, 0));
            send_req(t, n);
            run_frame({t, n}, -1, -1);
            ack_and_check("rand");
        end

        // Retry: ack only on the third attempt
        t = 3'($urandom_range(7, 0));
        n = 5'($urandom_range(25, 0));
        ready_seen = 0;
        send_req(t, n);
        run_frame({t, n}, -1, -1);
        wait_valid(TO + 10);
        run_frame({t, n}, -1, -1);
        wait_valid(TO + 10);
        run_frame({t, n}, -1, -1);
        check("retry_no_early_ready", 32'(ready_seen), 32'(0));
        ack_and_check("retry");
        check("retry_no_err", 32'(link_err), 32'(0));

        // Ack edge during SEND is ignored; held level gives no edge later, so a resend follows
        t = 3'($urandom_range(7, 0));
        n = 5'($urandom_range(25, 0));
        ready_seen = 0;
        ack_in = 1'b1;
        send_req(t, n);
        run_frame({t, n}, -1, -1);
        ack_in = 1'b0;
        wait_valid(TO + 10);
        check("send_ack_ignored", 32'(ready_seen), 32'(0));
        run_frame({t, n}, -1, -1);
        ack_and_check("send_ack");

        // Overrun: second request mid-frame is dropped
        check("ovr_before", 32'(overrun), 32'(0));
        send_req(3'b011, 5'd20);
        run_frame({3'b011, 5'd20}, 10, -1);
        check("ovr_set", 32'(overrun), 32'(1));
        ack_and_check("ovr");
        valid_seen = 0;
        observe(20);
        check("ovr_single_frame", 32'(valid_seen), 32'(0));
        check("ovr_sticky", 32'(overrun), 32'(1));

        // Abort: transmit drops during the third bit
        ready_seen = 0;
        valid_seen = 0;
        send_req(3'b101, 5'd6);
        run_frame({3'b101, 5'd6}, -1, 9);
        check("abort_valid", 32'(tx_valid), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        observe(30);
        check("abort_no_ready", 32'(ready_seen), 32'(0));
        check("abort_no_valid", 32'(valid_seen), 32'(0));
        transmit = 1'b1;
        tick();

        // Peer reset while waiting for ack
        send_req(3'b110, 5'd25);
        run_frame({3'b110, 5'd25}, -1, -1);
        check("ibrst_pre_busy", 32'(busy), 32'(1));
        interboard_rst = 1'b1;
        tick();
        check_all_zero("ibrst");
        interboard_rst = 1'b0;
        send_req(3'b000, 5'd0);
        run_frame(8'h00, -1, -1);
        ack_and_check("post_ibrst");

`ifdef INTERBOARD_PARITY_EN
        // Parity: F = 8'h23, odd number of ones -> parity bit 1, 36-cycle body
        send_req(3'b001, 5'd3);
        run_frame(8'h23, -1, -1);
        ack_and_check("parity");
`endif

        // Exhaustion: no ack ever -> 1 + MR frames, then sticky link_err
        t = 3'($urandom_range(7, 0));
        n = 5'($urandom_range(25, 0));
        send_req(t, n);
        run_frame({t, n}, -1, -1);
        for (int r = 0; r < MR; r++) begin
            wait_valid(TO + 10);
            run_frame({t, n}, -1, -1);
        end
        k = 0;
        while (!link_err && k < TO + 10) begin
            tick();
            k++;
        end
        check("exh_link_err", 32'(link_err), 32'(1));
        check("exh_busy", 32'(busy), 32'(0));
        check("exh_valid", 32'(tx_valid), 32'(0));
        valid_seen = 0;
        observe(TO + 10);
        check("exh_no_more_frames", 32'(valid_seen), 32'(0));
        send_req(3'b010, 5'd1);
        observe(10);
        check("exh_req_ignored", 32'(valid_seen), 32'(0));
        check("exh_err_sticky", 32'(link_err), 32'(1));
        check("exh_no_overrun", 32'(overrun), 32'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("exh_rst_clears", 32'(link_err), 32'(0));
        check("exh_rst_busy", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
